// File: rtl/param_core.sv
// param_core: small parameterised register-machine core.
//
// Executes 4-bit-opcode instructions against a REG_N x DATA_W register file.
// Most ops commit on the accepting edge. MUL is an iterative shift-add that
// takes DATA_W cycles. OUT hands a register value to a downstream consumer.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instr             {op[3:0], rd[RAW-1:0], rs[RAW-1:0]}; imm = rs zero-extended
//   instr_valid/ready instruction handshake
//   out_data/valid    value emitted by OUT
//   out_ready         consumer accepts out_data
//   flag_z, flag_c    zero and carry/borrow flags
//   busy              MUL in progress
//   halted            core stopped by HALT until reset
//   illegal           one-cycle pulse after a reserved opcode is accepted
//   dbg_state         current FSM state (0 RUN, 1 MUL, 2 HALT)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its payload stable while valid && !ready. Ready is
// never a function of valid.

module param_core #(
    parameter int DATA_W = 8,
    parameter int REG_N  = 16,
    localparam int RAW   = $clog2(REG_N),
    localparam int IW    = 4 + 2 * RAW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [1:0]        dbg_state
);

    localparam int CW = $clog2(DATA_W);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_CMP  = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MUL  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]   regs_q [REG_N];
    logic [DATA_W-1:0]   regs_d [REG_N];
    logic                flag_z_q, flag_z_d;
    logic                flag_c_q, flag_c_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                illegal_q, illegal_d;

    // MUL datapath: multiplicand shifts left, multiplier shifts right, and the
    // accumulator adds the multiplicand whenever the multiplier LSB is set.
    logic [2*DATA_W-1:0] mul_mcand_q, mul_mcand_d;
    logic [DATA_W-1:0]   mul_mplier_q, mul_mplier_d;
    logic [2*DATA_W-1:0] mul_acc_q, mul_acc_d;
    logic [RAW-1:0]      mul_rd_q, mul_rd_d;
    logic [CW-1:0]       mul_cnt_q, mul_cnt_d;

    logic [3:0]          op;
    logic [RAW-1:0]      rd_idx, rs_idx;
    logic [DATA_W-1:0]   rd_val, rs_val, imm;
    logic [DATA_W:0]     sum_w, diff_w;
    logic [2*DATA_W-1:0] mul_sum;
    logic                mul_last;
    logic                accept;

    assign op     = instr[IW-1 -: 4];
    assign rd_idx = instr[2*RAW-1 -: RAW];
    assign rs_idx = instr[RAW-1:0];
    assign rd_val = regs_q[rd_idx];
    assign rs_val = regs_q[rs_idx];
    assign imm    = DATA_W'(rs_idx);

    // Top bit of the widened add is the carry; of the widened subtract, the borrow.
    assign sum_w  = {1'b0, rd_val} + {1'b0, rs_val};
    assign diff_w = {1'b0, rd_val} - {1'b0, rs_val};

    assign mul_sum  = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
    assign mul_last = (state_q == ST_MUL) && (mul_cnt_q == CW'(DATA_W - 1));

    assign accept = instr_valid && instr_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && op == OP_MUL) begin
                    state_d = ST_MUL;
                end else if (accept && op == OP_HALT) begin
                    state_d = ST_HALT;
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Accept only in RUN and only when an accepted OUT could land in the
    // output register this same edge.
    always_comb begin
        instr_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
        busy        = (state_q == ST_MUL);
        halted      = (state_q == ST_HALT);
        dbg_state   = state_q;
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        regs_d       = regs_q;
        flag_z_d     = flag_z_q;
        flag_c_d     = flag_c_q;
        out_data_d   = out_data_q;
        // A pending output drains in every state, including HALT.
        out_valid_d  = out_valid_q && !out_ready;
        illegal_d    = 1'b0;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        mul_acc_d    = mul_acc_q;
        mul_rd_d     = mul_rd_q;
        mul_cnt_d    = mul_cnt_q;

        if (state_q == ST_MUL) begin
            mul_acc_d    = mul_sum;
            mul_mcand_d  = mul_mcand_q << 1;
            mul_mplier_d = mul_mplier_q >> 1;
            mul_cnt_d    = mul_cnt_q + CW'(1);
            if (mul_last) begin
                regs_d[mul_rd_q] = mul_sum[DATA_W-1:0];
                flag_z_d         = (mul_sum[DATA_W-1:0] == '0);
                flag_c_d         = |mul_sum[2*DATA_W-1:DATA_W];
            end
        end

        if (accept) begin
            case (op)
                OP_NOP: ;
                OP_ADD: begin
                    regs_d[rd_idx] = sum_w[DATA_W-1:0];
                    flag_z_d       = (sum_w[DATA_W-1:0] == '0);
                    flag_c_d       = sum_w[DATA_W];
                end
                OP_SUB: begin
                    regs_d[rd_idx] = diff_w[DATA_W-1:0];
                    flag_z_d       = (diff_w[DATA_W-1:0] == '0);
                    flag_c_d       = diff_w[DATA_W];
                end
                OP_LDI: begin
                    regs_d[rd_idx] = imm;
                    flag_z_d       = (imm == '0);
                end
                OP_MOV: begin
                    regs_d[rd_idx] = rs_val;
                    flag_z_d       = (rs_val == '0);
                end
                OP_AND: begin
                    regs_d[rd_idx] = rd_val & rs_val;
                    flag_z_d       = ((rd_val & rs_val) == '0);
                end
                OP_OR: begin
                    regs_d[rd_idx] = rd_val | rs_val;
                    flag_z_d       = ((rd_val | rs_val) == '0);
                end
                OP_XOR: begin
                    regs_d[rd_idx] = rd_val ^ rs_val;
                    flag_z_d       = ((rd_val ^ rs_val) == '0);
                end
                OP_SHL: begin
                    regs_d[rd_idx] = {rd_val[DATA_W-2:0], 1'b0};
                    flag_z_d       = (rd_val[DATA_W-2:0] == '0);
                    flag_c_d       = rd_val[DATA_W-1];
                end
                OP_SHR: begin
                    regs_d[rd_idx] = {1'b0, rd_val[DATA_W-1:1]};
                    flag_z_d       = (rd_val[DATA_W-1:1] == '0);
                    flag_c_d       = rd_val[0];
                end
                OP_CMP: begin
                    flag_z_d = (diff_w[DATA_W-1:0] == '0);
                    flag_c_d = diff_w[DATA_W];
                end
                OP_OUT: begin
                    // A new OUT replaces a value being handed off this edge.
                    out_data_d  = rd_val;
                    out_valid_d = 1'b1;
                end
                OP_MUL: begin
                    mul_mcand_d  = {{DATA_W{1'b0}}, rd_val};
                    mul_mplier_d = rs_val;
                    mul_acc_d    = '0;
                    mul_rd_d     = rd_idx;
                    mul_cnt_d    = '0;
                end
                OP_HALT: ;
                default: illegal_d = 1'b1;  // reserved opcodes act as NOP
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
            flag_z_q     <= 1'b0;
            flag_c_q     <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_acc_q    <= '0;
            mul_rd_q     <= '0;
            mul_cnt_q    <= '0;
        end else begin
            regs_q       <= regs_d;
            flag_z_q     <= flag_z_d;
            flag_c_q     <= flag_c_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            illegal_q    <= illegal_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            mul_acc_q    <= mul_acc_d;
            mul_rd_q     <= mul_rd_d;
            mul_cnt_q    <= mul_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_param_core.sv
// tb_param_core: directed test of param_core with DATA_W=8, REG_N=16.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.

module tb_param_core;

  logic        clk;
  logic        rst;
  logic [11:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flag_z;
  logic        flag_c;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;

  param_core #(.DATA_W(8), .REG_N(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- drivers ----------------
  // Present one instruction, wait (bounded) for ready, complete the transfer.
  // Returns 1 ns after the accepting edge.
  task automatic issue(input logic [11:0] i);
    int n;
    n = 0;
    instr       = i;
    instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (instr_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: instr %h not accepted after %0d cycles", i, n);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  // Read a register through OUT (out_ready held high); leaves flags alone.
  task automatic read_reg(input logic [3:0] r, output logic [7:0] val);
    out_ready = 1'b1;
    issue({4'hB, r, 4'h0});
    val = out_data;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for instr_ready; returns number of edges waited.
  task automatic wait_ready(output int n);
    n = 0;
    while (instr_ready !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    vectors++;
    if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_out: got valid %b data %h want 0 00", out_valid, out_data);
    end
    vectors++;
    if ({flag_z, flag_c, busy, halted, illegal} !== 5'b0) begin
      miscompares++; $display("FAIL reset_status: got zcbhi %b want 00000", {flag_z, flag_c, busy, halted, illegal});
    end
    vectors++;
    if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    read_reg(4'd3, v);
    vectors++;
    if (v !== 8'h00) begin miscompares++; $display("FAIL reset_r3: got %h want 00", v); end
  endtask

  task automatic test_add_out();
    issue(12'h335);
    issue(12'h342);
    issue(12'h134);
    vectors++;
    if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
      miscompares++; $display("FAIL add_flags: got z%b c%b want z0 c0", flag_z, flag_c);
    end
    out_ready = 1'b1;
    issue(12'hB30);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h07) begin
      miscompares++; $display("FAIL out_first: got valid %b data %h want 1 07", out_valid, out_data);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL out_drop: got valid %b want 0", out_valid); end
  endtask

  task automatic test_sub_cmp();
    logic [7:0] v;
    issue(12'h310);
    issue(12'h321);
    issue(12'h212);
    vectors++;
    if (flag_z !== 1'b0 || flag_c !== 1'b1) begin
      miscompares++; $display("FAIL sub_flags: got z%b c%b want z0 c1", flag_z, flag_c);
    end
    read_reg(4'd1, v);
    vectors++;
    if (v !== 8'hFF) begin miscompares++; $display("FAIL sub_r1: got %h want ff", v); end
    issue(12'hA11);
    vectors++;
    if (flag_z !== 1'b1 || flag_c !== 1'b0) begin
      miscompares++; $display("FAIL cmp_flags: got z%b c%b want z1 c0", flag_z, flag_c);
    end
    read_reg(4'd1, v);
    vectors++;
    if (v !== 8'hFF) begin miscompares++; $display("FAIL cmp_r1: got %h want ff", v); end
  endtask

  // Runs after test_sub_cmp: r1=FF, r2=01.
  task automatic test_flags();
    logic [7:0] v;
    issue(12'h112);  // FF + 01 -> 00, carry out
    vectors++;
    if (flag_z !== 1'b1 || flag_c !== 1'b1) begin
      miscompares++; $display("FAIL add_carry: got z%b c%b want z1 c1", flag_z, flag_c);
    end
    issue(12'h312);
    issue(12'h512);  // 02 & 01 -> 00, C kept
    vectors++;
    if (flag_z !== 1'b1 || flag_c !== 1'b1) begin
      miscompares++; $display("FAIL and_flags: got z%b c%b want z1 c1", flag_z, flag_c);
    end
    issue(12'h39F);
    issue(12'h890);  // 0F << 1 -> 1E, C=0
    vectors++;
    if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
      miscompares++; $display("FAIL shl_flags: got z%b c%b want z0 c0", flag_z, flag_c);
    end
    issue(12'h381);
    issue(12'h980);  // 01 >> 1 -> 00, C=1
    vectors++;
    if (flag_z !== 1'b1 || flag_c !== 1'b1) begin
      miscompares++; $display("FAIL shr_flags: got z%b c%b want z1 c1", flag_z, flag_c);
    end
    read_reg(4'd9, v);
    vectors++;
    if (v !== 8'h1E) begin miscompares++; $display("FAIL shl_r9: got %h want 1e", v); end
    issue(12'h3A3);
    issue(12'h49A);  // r9 = r10 = 03, C kept
    vectors++;
    if (flag_z !== 1'b0 || flag_c !== 1'b1) begin
      miscompares++; $display("FAIL mov_flags: got z%b c%b want z0 c1", flag_z, flag_c);
    end
    issue(12'h799);  // r9 ^= r9 -> 00
    vectors++;
    if (flag_z !== 1'b1) begin miscompares++; $display("FAIL xor_z: got %b want 1", flag_z); end
  endtask

  task automatic test_mul();
    logic [7:0] v;
    int n;
    issue(12'h35F);
    issue(12'h36F);
    issue(12'hC56);
    vectors++;
    if (busy !== 1'b1 || instr_ready !== 1'b0 || dbg_state !== 2'd1) begin
      miscompares++; $display("FAIL mul_enter: got busy %b ready %b state %0d want 1 0 1", busy, instr_ready, dbg_state);
    end
    wait_ready(n);
    vectors++;
    if (n != 8) begin miscompares++; $display("FAIL mul_latency: got %0d want 8", n); end
    vectors++;
    if (busy !== 1'b0 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      miscompares++; $display("FAIL mul1_flags: got busy %b z%b c%b want 0 z0 c0", busy, flag_z, flag_c);
    end
    read_reg(4'd5, v);
    vectors++;
    if (v !== 8'hE1) begin miscompares++; $display("FAIL mul1_r5: got %h want e1", v); end
    issue(12'hC55);  // E1 * E1 = C5C1
    wait_ready(n);
    vectors++;
    if (flag_z !== 1'b0 || flag_c !== 1'b1) begin
      miscompares++; $display("FAIL mul2_flags: got z%b c%b want z0 c1", flag_z, flag_c);
    end
    read_reg(4'd5, v);
    vectors++;
    if (v !== 8'hC1) begin miscompares++; $display("FAIL mul2_r5: got %h want c1", v); end
  endtask

  task automatic test_backpressure();
    logic [7:0] v;
    issue(12'h335);
    issue(12'h342);
    out_ready = 1'b0;
    issue(12'hB30);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h05) begin
      miscompares++; $display("FAIL bp_out: got valid %b data %h want 1 05", out_valid, out_data);
    end
    instr       = 12'h134;
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (instr_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h05) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d got ready %b valid %b data %h want 0 1 05", k, instr_ready, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got ready %b want 1", instr_ready); end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_handoff: got valid %b want 0", out_valid); end
    read_reg(4'd3, v);
    vectors++;
    if (v !== 8'h07) begin miscompares++; $display("FAIL bp_add: got r3 %h want 07", v); end
    // New OUT accepted on the handoff edge replaces the pending value.
    out_ready = 1'b0;
    issue(12'hB40);
    out_ready = 1'b1;
    issue(12'hB30);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h07) begin
      miscompares++; $display("FAIL back_to_back_out: got valid %b data %h want 1 07", out_valid, out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_illegal_halt();
    logic [7:0] v;
    int bad;
    issue(12'h321);
    issue(12'h310);
    issue(12'h212);  // r1=FF, Z=0, C=1
    issue(12'hE00);
    vectors++;
    if (illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_pulse: got %b want 1", illegal); end
    @(posedge clk);
    #1;
    vectors++;
    if (illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_clear: got %b want 0", illegal); end
    vectors++;
    if (flag_z !== 1'b0 || flag_c !== 1'b1) begin
      miscompares++; $display("FAIL illegal_flags: got z%b c%b want z0 c1", flag_z, flag_c);
    end
    read_reg(4'd1, v);
    vectors++;
    if (v !== 8'hFF) begin miscompares++; $display("FAIL illegal_r1: got %h want ff", v); end
    issue(12'hD00);
    vectors++;
    if (halted !== 1'b1 || instr_ready !== 1'b0 || dbg_state !== 2'd2) begin
      miscompares++; $display("FAIL halt_enter: got halted %b ready %b state %0d want 1 0 2", halted, instr_ready, dbg_state);
    end
    instr       = 12'h335;
    instr_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (instr_ready !== 1'b0 || halted !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL halt_hold: got %0d ready cycles want 0", bad); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    instr_valid = 1'b0;
    vectors++;
    if ({halted, busy, illegal, flag_z, flag_c, out_valid} !== 6'b0 || instr_ready !== 1'b1 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL halt_reset: got hbizcv %b ready %b data %h want 000000 1 00",
               {halted, busy, illegal, flag_z, flag_c, out_valid}, instr_ready, out_data);
    end
    read_reg(4'd1, v);
    vectors++;
    if (v !== 8'h00) begin miscompares++; $display("FAIL halt_reset_r1: got %h want 00", v); end
  endtask

  task automatic test_reset_mid_mul();
    logic [7:0] v;
    issue(12'h35F);
    issue(12'h36F);
    issue(12'hC56);
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b1;
    instr       = 12'h37F;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    instr_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || instr_ready !== 1'b1) begin
      miscompares++; $display("FAIL mulrst_state: got busy %b state %0d ready %b want 0 0 1", busy, dbg_state, instr_ready);
    end
    repeat (12) @(posedge clk);
    #1;
    read_reg(4'd5, v);
    vectors++;
    if (v !== 8'h00) begin miscompares++; $display("FAIL mulrst_r5: got %h want 00", v); end
    read_reg(4'd7, v);
    vectors++;
    if (v !== 8'h00) begin miscompares++; $display("FAIL mulrst_r7: got %h want 00", v); end
    // Reset wins over an instruction accepted on the same edge in RUN.
    rst         = 1'b1;
    instr       = 12'h33F;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    instr_valid = 1'b0;
    read_reg(4'd3, v);
    vectors++;
    if (v !== 8'h00) begin miscompares++; $display("FAIL rst_accept_r3: got %h want 00", v); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    out_ready   = 1'b1;
    #1;
    test_reset();
    test_add_out();
    test_sub_cmp();
    test_flags();
    test_mul();
    test_backpressure();
    test_illegal_halt();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
